// File: rtl/fx3_stream_pkg.sv
// rtl/fx3_stream_pkg.sv - shared types and helpers for the FX3 stream-in sequencer
package fx3_stream_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, STREAM, GAP} fx3_ctrl_state_t;

    localparam int BUF_WORDS_DEF = 4092;

    // Counter width able to hold 0..words-1, never narrower than one bit.
    function automatic int wcnt_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/fx3_burst_counter.sv
// rtl/fx3_burst_counter.sv - restartable up-counter flagging its terminal count
module fx3_burst_counter
    import fx3_stream_pkg::*;
#(
    parameter int TERM = BUF_WORDS_DEF
) (
    input  logic aclk,
    input  logic resetn,
    input  logic start,
    input  logic tick,
    output logic last
);

    localparam int W = wcnt_w(TERM);

    logic [W-1:0] cnt;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

    assign last = (cnt == W'(TERM - 1));

endmodule

// File: rtl/fx3_stream_in_ctrl.sv
// rtl/fx3_stream_in_ctrl.sv - buffer-level sequencer between stream-in FIFO and FX3 GPIF read port
module fx3_stream_in_ctrl
    import fx3_stream_pkg::*;
#(
    parameter int BUF_WORDS  = BUF_WORDS_DEF,
    parameter int FIFO_CNT_W = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  fx3_resetn,
    input  logic [FIFO_CNT_W-1:0] fifo_count,
    input  logic                  fifo_empty,
    input  logic                  fifo_overflow,
    output logic                  fifo_rd_en,
    input  logic                  fx3_read_ready,
    output logic                  fx3_data_available,
    output logic                  thread_sel,
    output logic                  buf_done,
    output logic [31:0]           buf_count,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  proto_err
);

    fx3_ctrl_state_t state;
    logic            rr_q;
    logic            req;
    logic            run;
    logic            in_stream;
    logic            word_last;
    logic            gap_last;

    assign req       = fx3_read_ready ^ rr_q;
    assign run       = aresetn & fx3_resetn;
    assign in_stream = (state == STREAM);

    // Pop and done are gated by reset so an abandoned slot never pops or completes.
    assign fifo_rd_en = run & in_stream & ~fifo_empty;
    assign buf_done   = run & in_stream & word_last;

    fx3_burst_counter #(.TERM(BUF_WORDS)) u_word_cnt (
        .aclk   (aclk),
        .resetn (run),
        .start  ((state == ARMED) & req),
        .tick   (in_stream),
        .last   (word_last)
    );

    fx3_burst_counter #(.TERM(GAP_CYCLES)) u_gap_cnt (
        .aclk   (aclk),
        .resetn (run),
        .start  (in_stream & word_last),
        .tick   (state == GAP),
        .last   (gap_last)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state              <= IDLE;
            rr_q               <= fx3_read_ready;
            fx3_data_available <= 1'b0;
            thread_sel         <= 1'b0;
            buf_count          <= 32'd0;
            overflow           <= 1'b0;
            underrun           <= 1'b0;
            proto_err          <= 1'b0;
        end else begin
            rr_q <= fx3_read_ready;
            if (fifo_overflow) overflow <= 1'b1;
            // Soft reset keeps the counter and sticky flags for the host to inspect.
            if (!fx3_resetn) begin
                state              <= IDLE;
                fx3_data_available <= 1'b0;
                thread_sel         <= 1'b0;
            end else begin
                if (req && state != ARMED) proto_err <= 1'b1;
                if (in_stream && fifo_empty) underrun <= 1'b1;
                case (state)
                    IDLE: begin
                        if (fifo_count >= FIFO_CNT_W'(BUF_WORDS)) begin
                            state              <= ARMED;
                            fx3_data_available <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (req) begin
                            state              <= STREAM;
                            fx3_data_available <= 1'b0;
                        end
                    end
                    STREAM: begin
                        if (word_last) begin
                            state      <= GAP;
                            thread_sel <= ~thread_sel;
                            buf_count  <= buf_count + 32'd1;
                        end
                    end
                    GAP: begin
                        if (gap_last) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
